// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- UART receiver with an integrated receive FIFO.
//
// Deserialises an asynchronous serial line (start + DATA_BITS LSB first
// [+ parity] + stop), checks the stop bit, optionally checks parity, and
// buffers good words in a circular FIFO popped through ready/valid.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> a parity bit follows the data bits and is checked
//                (even parity, or odd when PARITY_ODD = 1)
//   undefined -> no parity bit; parity_err is constant 0
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   asynchronous active-high reset
//   serial_in      in   raw serial line, idles high
//   data_out       out  FIFO head word
//   data_out_valid out  FIFO non-empty
//   data_out_ready in   consumer accepts the head word
//   fifo_count     out  current FIFO occupancy
//   overrun        out  1-cycle pulse: good word dropped, FIFO full
//   frame_err      out  1-cycle pulse: stop bit sampled low
//   parity_err     out  1-cycle pulse: parity mismatch
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  output logic [DATA_BITS-1:0]          data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int SAMPLE_TICKS = CLOCK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(SAMPLE_TICKS);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] TICK_MID  = TW'(SAMPLE_TICKS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_V   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------- sync
  logic sync_q1, rx;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values; blocking here would collapse the two-flop
  // synchroniser into one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      rx      <= 1'b1;
    end else begin
      sync_q1 <= serial_in;
      rx      <= sync_q1;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t                state;
  logic [TW-1:0]         tick;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  push;

  wire at_sample = (tick == TICK_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign push = (state == STOP) && at_sample && rx && !par_bad;
`else
  logic parity_odd_unused;
  assign parity_odd_unused = 1'(PARITY_ODD);
  assign push       = (state == STOP) && at_sample && rx;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          tick <= '0;
          if (!rx) state <= START;
        end
        START: begin
          // Mid-start check rejects glitches shorter than half a bit.
          if (tick == TICK_MID) begin
            tick    <= '0;
            bit_cnt <= '0;
            state   <= rx ? IDLE : DATA;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        DATA: begin
          if (at_sample) begin
            tick  <= '0;
            shreg <= {rx, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_sample) begin
            tick    <= '0;
            par_bad <= rx ^ (^shreg) ^ 1'(PARITY_ODD);
            state   <= STOP;
          end else begin
            tick <= tick + TW'(1);
          end
        end
`endif
        STOP: begin
          if (at_sample) begin
            tick <= '0;
            if (!rx) begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end else begin
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
`endif
              state <= IDLE;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        WAIT_IDLE: begin
          // Hold off until the line recovers so a break cannot retrigger.
          tick <= '0;
          if (rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;

  wire full = (fifo_count == DEPTH_V);
  wire pop  = data_out_valid && data_out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  wire wr   = push && (!full || pop);

  assign fifo_count     = wr_ptr - rd_ptr;
  assign data_out_valid = (wr_ptr != rd_ptr);
  assign data_out       = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array is reset on purpose so data_out reads 0 after
  // reset; this costs a reset net per storage flop instead of plain RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= push && full && !pop;
      if (wr) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + (AW + 1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

endmodule
